// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/halt controller for a classic 5-stage pipeline.
// A small FSM (RUN, MWAIT, DRAIN, HALTED) plus a 2-bit drain counter decides,
// combinationally each cycle, which pipeline registers load and which receive
// a bubble. Input priority: mem_busy > branch_taken > halt_req > load_use.
// Optional build macro PIPE_HAZARD_CTRL_PERF_EN adds two saturating 16-bit
// performance counters (stall_cycles, flush_events).
module pipe_hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_use,
  input  logic       branch_taken,
  input  logic       mem_busy,
  input  logic       halt_req,
  output logic       en_pc,
  output logic       en_ifid,
  output logic       en_idex,
  output logic       en_exmem,
  output logic       en_memwb,
  output logic       flush_ifid,
  output logic       flush_idex,
  output logic [1:0] state,
  output logic       halted
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [15:0] stall_cycles,
  output logic [15:0] flush_events
`endif
);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_MWAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_HALTED = 2'd3;

  logic [1:0] r_state;
  logic [1:0] r_drain_cnt;
  logic [1:0] w_state_nxt;
  logic [1:0] w_drain_cnt_nxt;

  assign state = r_state;

  // State and drain-counter registers; reset aborts any drain or memory wait.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_drain_cnt <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_drain_cnt <= w_drain_cnt_nxt;
    end
  end

  // Next-state and drain-counter decode from current state and prioritised inputs.
  always_comb begin
    w_state_nxt     = r_state;
    w_drain_cnt_nxt = r_drain_cnt;
    case (r_state)
      // MWAIT exits through the same decode as RUN once memory is ready.
      S_RUN, S_MWAIT: begin
        if (mem_busy) begin
          w_state_nxt = S_MWAIT;
        end else if (branch_taken) begin
          w_state_nxt = S_RUN;
        end else if (halt_req) begin
          w_state_nxt     = S_DRAIN;
          w_drain_cnt_nxt = 2'd3;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (mem_busy) begin
          w_state_nxt = S_DRAIN;
        end else if (load_use && !branch_taken) begin
          // Load-use stall holds the drain without advancing.
          w_state_nxt = S_DRAIN;
        end else if (r_drain_cnt == 2'd1) begin
          w_state_nxt     = S_HALTED;
          w_drain_cnt_nxt = 2'd0;
        end else begin
          w_drain_cnt_nxt = r_drain_cnt - 2'd1;
        end
      end
      S_HALTED: begin
        w_state_nxt = S_HALTED;
      end
      default: begin
        w_state_nxt     = S_RUN;
        w_drain_cnt_nxt = 2'd0;
      end
    endcase
  end

  // Enable/flush decode; everything is forced inactive while reset is asserted.
  always_comb begin
    en_pc      = 1'b0;
    en_ifid    = 1'b0;
    en_idex    = 1'b0;
    en_exmem   = 1'b0;
    en_memwb   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    halted     = 1'b0;
    if (rst) begin
      halted = 1'b0;
    end else begin
      case (r_state)
        S_RUN, S_MWAIT: begin
          if (mem_busy) begin
            en_pc = 1'b0;
          end else if (branch_taken) begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
          end else if (halt_req) begin
            {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
            flush_ifid = 1'b1;
          end else if (load_use) begin
            {en_idex, en_exmem, en_memwb} = 3'b111;
            flush_idex = 1'b1;
          end else begin
            {en_pc, en_ifid, en_idex, en_exmem, en_memwb} = 5'b11111;
          end
        end
        S_DRAIN: begin
          if (mem_busy) begin
            en_pc = 1'b0;
          end else begin
            // Fetch stays stopped and IF/ID keeps taking bubbles while draining.
            {en_ifid, en_idex, en_exmem, en_memwb} = 4'b1111;
            flush_ifid = 1'b1;
            if (branch_taken) begin
              flush_idex = 1'b1;
            end else if (load_use) begin
              en_ifid    = 1'b0;
              flush_idex = 1'b1;
            end else begin
              flush_idex = 1'b0;
            end
          end
        end
        S_HALTED: begin
          halted = 1'b1;
        end
        default: begin
          halted = 1'b0;
        end
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating counters: cycles with fetch stalled (outside HALTED) and
  // cycles where a taken branch squashes ID/EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
      flush_events <= 16'd0;
    end else begin
      if (!en_pc && (r_state != S_HALTED) && (stall_cycles != 16'hFFFF)) begin
        stall_cycles <= stall_cycles + 16'd1;
      end else begin
        stall_cycles <= stall_cycles;
      end
      if (flush_idex && branch_taken && (flush_events != 16'hFFFF)) begin
        flush_events <= flush_events + 16'd1;
      end else begin
        flush_events <= flush_events;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random input traffic, all compared against a rule-level reference model.
module tb_pipe_hazard_ctrl;

  logic clk;
  logic rst;
  logic load_use, branch_taken, mem_busy, halt_req;
  logic en_pc, en_ifid, en_idex, en_exmem, en_memwb;
  logic flush_ifid, flush_idex;
  logic [1:0] state;
  logic halted;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: mode 0 RUN,1 MWAIT,2 DRAIN,3 HALTED; drain cycles left.
  int m_mode = 0;
  int m_left = 0;
  int m_stall = 0;
  int m_flush = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .load_use(load_use), .branch_taken(branch_taken),
    .mem_busy(mem_busy), .halt_req(halt_req),
    .en_pc(en_pc), .en_ifid(en_ifid), .en_idex(en_idex),
    .en_exmem(en_exmem), .en_memwb(en_memwb),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .state(state), .halted(halted)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cycles(stall_cycles), .flush_events(flush_events)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected outputs ordered {en_pc,en_ifid,en_idex,en_exmem,en_memwb,flush_ifid,flush_idex}.
  task automatic model_eval(input logic lu, input logic br, input logic mb, input logic hr,
                            output logic [6:0] exp_o, output int nmode, output int nleft,
                            output bit brf);
    bit advance;
    advance = 1'b0;
    brf     = 1'b0;
    nmode   = m_mode;
    nleft   = m_left;
    exp_o   = 7'b0000000;
    if (m_mode == 0 || m_mode == 1) begin
      if (mb) begin
        exp_o = 7'b0000000; nmode = 1;
      end else if (br) begin
        exp_o = 7'b1111111; nmode = 0; brf = 1'b1;
      end else if (hr) begin
        exp_o = 7'b0111110; nmode = 2; nleft = 3;
      end else if (lu) begin
        exp_o = 7'b0011101; nmode = 0;
      end else begin
        exp_o = 7'b1111100; nmode = 0;
      end
    end else if (m_mode == 2) begin
      if (mb) begin
        exp_o = 7'b0000000;
      end else if (br) begin
        exp_o = 7'b0111111; brf = 1'b1; advance = 1'b1;
      end else if (lu) begin
        exp_o = 7'b0011111;
      end else begin
        exp_o = 7'b0111110; advance = 1'b1;
      end
      if (advance) begin
        nleft = m_left - 1;
        if (nleft == 0) nmode = 3;
      end
    end else begin
      exp_o = 7'b0000000;
    end
  endtask

  task automatic check_outputs(input string tag, input logic [6:0] exp_o, input int mode);
    chk({tag, ".outs"},
        {25'd0, en_pc, en_ifid, en_idex, en_exmem, en_memwb, flush_ifid, flush_idex},
        {25'd0, exp_o});
    chk({tag, ".state"}, {30'd0, state}, 32'(mode));
    chk({tag, ".halted"}, {31'd0, halted}, (mode == 3) ? 32'd1 : 32'd0);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    chk({tag, ".stall_cnt"}, {16'd0, stall_cycles}, 32'(m_stall));
    chk({tag, ".flush_cnt"}, {16'd0, flush_events}, 32'(m_flush));
`endif
  endtask

  // One clock cycle: drive at negedge, check mid-cycle, advance model at posedge.
  task automatic step(input logic lu, input logic br, input logic mb, input logic hr,
                      input string tag);
    logic [6:0] exp_o;
    int nmode, nleft;
    bit brf;
    @(negedge clk);
    load_use = lu; branch_taken = br; mem_busy = mb; halt_req = hr;
    #1;
    model_eval(lu, br, mb, hr, exp_o, nmode, nleft, brf);
    check_outputs(tag, exp_o, m_mode);
    @(posedge clk);
    if (exp_o[6] == 1'b0 && m_mode != 3 && m_stall < 65535) m_stall++;
    if (brf && m_flush < 65535) m_flush++;
    m_mode = nmode;
    m_left = nleft;
  endtask

  // Asynchronous reset mid-cycle with random inputs applied; outputs must drop at once.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    load_use = 1'($urandom_range(0, 1));
    branch_taken = 1'($urandom_range(0, 1));
    mem_busy = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    rst = 1'b1;
    m_mode = 0; m_left = 0; m_stall = 0; m_flush = 0;
    #1;
    check_outputs(tag, 7'b0000000, 0);
    chk({tag, ".rst_halted"}, {31'd0, halted}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    load_use = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    load_use = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0; halt_req = 1'b0;
    do_reset("por");

    // Idle after reset: full flow.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "idle");
    chk("idle.en_all", {27'd0, en_pc, en_ifid, en_idex, en_exmem, en_memwb}, 32'h1F);

    // Single load-use bubble, then recovery.
    step(1'b1, 1'b0, 1'b0, 1'b0, "lu");
    step(1'b0, 1'b0, 1'b0, 1'b0, "lu_after");

    // Branch beats load-use.
    step(1'b1, 1'b1, 1'b0, 1'b0, "br_lu");

    // Memory wait of 4 cycles, then release with RUN decode in the same cycle.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "mwait");
    step(1'b0, 1'b0, 1'b0, 1'b0, "mwait_exit");
    step(1'b0, 1'b0, 1'b0, 1'b0, "mwait_run");

    // Halt with memory stalls inside the drain.
    step(1'b0, 1'b0, 1'b0, 1'b1, "halt");
    step(1'b0, 1'b0, 1'b1, 1'b0, "drain_mb0");
    step(1'b0, 1'b0, 1'b1, 1'b0, "drain_mb1");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "drain");
    step(1'b1, 1'b1, 1'b0, 1'b1, "halted");
    step(1'b0, 1'b0, 1'b1, 1'b0, "halted2");
    do_reset("rst_halted");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

    // Reset abort in the middle of a drain and a memory wait.
    step(1'b0, 1'b0, 1'b0, 1'b1, "halt2");
    step(1'b0, 1'b0, 1'b0, 1'b0, "drain2");
    do_reset("rst_drain");
    step(1'b0, 1'b0, 1'b1, 1'b0, "mw2");
    step(1'b0, 1'b0, 1'b1, 1'b0, "mw3");
    do_reset("rst_mwait");
    step(1'b0, 1'b0, 1'b0, 1'b0, "post_rst2");

    // Halt on memory-wait exit; load-use and branch inside drain.
    step(1'b0, 1'b0, 1'b1, 1'b0, "mw4");
    step(1'b1, 1'b0, 1'b0, 1'b1, "mw_exit_halt");
    step(1'b1, 1'b0, 1'b0, 1'b0, "drain_lu");
    step(1'b1, 1'b1, 1'b0, 1'b0, "drain_br");
    step(1'b0, 1'b0, 1'b0, 1'b0, "drain_a");
    step(1'b0, 1'b0, 1'b0, 1'b0, "drain_b");
    step(1'b0, 1'b0, 1'b0, 1'b0, "halted3");

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    do_reset("rst_perf");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, "perf_lu");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, 1'b0, 1'b0, "perf_br");
    #1;
    chk("perf.stall_total", {16'd0, stall_cycles}, 32'd3);
    chk("perf.flush_total", {16'd0, flush_events}, 32'd2);
`endif

    // Random traffic; occasionally reset out of HALTED or mid-flight.
    do_reset("rst_rnd");
    for (int i = 0; i < 500; i++) begin
      if ((m_mode == 3 && $urandom_range(0, 2) == 0) || $urandom_range(0, 99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        step(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0), "rnd");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
